delta_spike_encoder: RTL

Parametrised multi-channel delta-modulation spike encoder, the successor to the single-channel up/down comparator encoder. Each channel keeps a reference level, compares every new sample against it with a programmable threshold, and emits separate UP and DOWN spikes. Each channel's reference moves one threshold step per spike. The block sits between the sample source (ADC/data loader) and the spiking network input stage, with valid/ready handshakes on both sides.

---
 rtl/spike_enc_pkg.sv | 22 ++
 rtl/delta_spike_encoder_if.sv | 23 ++
 rtl/spike_enc_channel.sv | 76 +++++++
 rtl/delta_spike_encoder.sv | 107 ++++++++++
 4 files changed

// File: rtl/spike_enc_pkg.sv
// Shared types and width helpers for the delta spike encoder.
package spike_enc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam int DEF_DATA_W = 8;
    localparam int DIFF_W     = DEF_DATA_W + 1;

    // One extra bit so sample - ref never overflows.
    function automatic int diff_w(input int data_w);
        return data_w + (DIFF_W - DEF_DATA_W);
    endfunction

    function automatic int cnt_w(input int refract);
        return $clog2(refract + 1);
    endfunction

endpackage

// File: rtl/delta_spike_encoder_if.sv
// Sample-in / spike-out handshake bundle for delta_spike_encoder.
interface delta_spike_encoder_if #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 4
);
    logic                         in_valid;
    logic                         in_ready;
    logic [CHANNELS*DATA_W-1:0]   data;
    logic                         out_valid;
    logic                         out_ready;
    logic [CHANNELS-1:0]          spike_up;
    logic [CHANNELS-1:0]          spike_down;

    modport master (
        output in_valid, data, out_ready,
        input  in_ready, out_valid, spike_up, spike_down
    );

    modport slave (
        input  in_valid, data, out_ready,
        output in_ready, out_valid, spike_up, spike_down
    );
endinterface

// File: rtl/spike_enc_channel.sv
// One delta-modulation channel: reference register, signed compare, step update.
// Optional refractory counter under SPIKE_REFRACTORY_EN.
module spike_enc_channel
    import spike_enc_pkg::*;
#(
    parameter int DATA_W  = 8
`ifdef SPIKE_REFRACTORY_EN
    ,
    parameter int REFRACT = 2
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] thr,
    input  logic [DATA_W-1:0] sample,
    output logic              up,
    output logic              dn
);
    localparam int DW = diff_w(DATA_W);

    function automatic logic [DATA_W-1:0] eff_thr(input logic [DATA_W-1:0] t);
        return (t == '0) ? DATA_W'(1) : t;
    endfunction

    logic        [DATA_W-1:0] ref_lvl;
    logic        [DATA_W-1:0] thr_eff;
    logic signed [DW-1:0]     diff;
    logic signed [DW-1:0]     thr_s;
    logic                     raw_up;
    logic                     raw_dn;

    assign thr_eff = eff_thr(thr);
    assign diff    = $signed({1'b0, sample}) - $signed({1'b0, ref_lvl});
    assign thr_s   = $signed({1'b0, thr_eff});
    assign raw_up  = (diff >= thr_s);
    assign raw_dn  = (diff <= -thr_s);

`ifdef SPIKE_REFRACTORY_EN
    localparam int CW = cnt_w(REFRACT);
    logic [CW-1:0] cnt;
    logic          quiet;

    assign quiet = (cnt != '0);
    assign up    = raw_up && !quiet;
    assign dn    = raw_dn && !quiet;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt <= '0;
        end else if (step) begin
            if (quiet)
                cnt <= cnt - CW'(1);
            else if (raw_up || raw_dn)
                cnt <= CW'(REFRACT);
        end
    end
`else
    assign up = raw_up;
    assign dn = raw_dn;
`endif

    // The step never overshoots the sample, so no saturation is needed.
    always_ff @(posedge clk) begin
        if (rst)
            ref_lvl <= '0;
        else if (load)
            ref_lvl <= sample;
        else if (step && up)
            ref_lvl <= ref_lvl + thr_eff;
        else if (step && dn)
            ref_lvl <= ref_lvl - thr_eff;
    end

endmodule

// File: rtl/delta_spike_encoder.sv
// Multi-channel delta spike encoder: FSM, handshakes and spike output register.
// Define SPIKE_REFRACTORY_EN to add per-channel refractory counters.
module delta_spike_encoder
    import spike_enc_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 4,
    parameter int REFRACT  = 2
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] threshold,
    delta_spike_encoder_if.slave bus
);
    if (CHANNELS < 1 || REFRACT < 1) begin : g_param_check
        $error("delta_spike_encoder: CHANNELS and REFRACT must be >= 1");
    end

    state_e              state;
    logic                in_ready_c;
    logic                accept;
    logic                load;
    logic                step;
    logic                drain_ok;
    logic [CHANNELS-1:0] up_p0;
    logic [CHANNELS-1:0] dn_p0;
    logic                vld_p1;
    logic [CHANNELS-1:0] up_p1;
    logic [CHANNELS-1:0] dn_p1;

    assign drain_ok = !vld_p1 || bus.out_ready;

    always_comb begin
        in_ready_c = 1'b0;
        if (!reset && start) begin
            case (state)
                ST_PRIME: in_ready_c = 1'b1;
                ST_RUN:   in_ready_c = drain_ok;
                default:  in_ready_c = 1'b0;
            endcase
        end
    end

    assign accept = bus.in_valid && in_ready_c;
    assign load   = accept && (state == ST_PRIME);
    assign step   = accept && (state == ST_RUN);

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start) state <= ST_PRIME;
                ST_PRIME: begin
                    if (!start)
                        state <= ST_IDLE;
                    else if (load)
                        state <= ST_RUN;
                end
                ST_RUN:   if (!start && drain_ok) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Stage p0: per-channel compare on the incoming beat
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        spike_enc_channel #(
            .DATA_W  (DATA_W)
`ifdef SPIKE_REFRACTORY_EN
            ,
            .REFRACT (REFRACT)
`endif
        ) u_ch (
            .clk    (CLK100MHZ),
            .rst    (reset),
            .load   (load),
            .step   (step),
            .thr    (threshold),
            .sample (bus.data[c*DATA_W +: DATA_W]),
            .up     (up_p0[c]),
            .dn     (dn_p0[c])
        );
    end

    // Stage p1: registered spike vector, held while backpressured
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            up_p1  <= '0;
            dn_p1  <= '0;
        end else if (step) begin
            vld_p1 <= 1'b1;
            up_p1  <= up_p0;
            dn_p1  <= dn_p0;
        end else if (bus.out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = vld_p1;
    assign bus.spike_up   = up_p1;
    assign bus.spike_down = dn_p1;

endmodule
